reset_seq_gen: RTL and testbench

Reset sequence generator that drives the asynchronous preset and clear pins of downstream async-preset/clear flip-flops. It turns a raw asynchronous power-on reset and a synchronous software reset request into clean control outputs for those flops. Each output asserts immediately (asynchronously for power-on), is held for a programmable number of cycles, and deasserts synchronously to `clk`. It sits at the root of each clock domain's reset tree, upstream of every preset/clear flop bank.

---
 rtl/reset_seq_gen.sv | 95 +++++++++
 tb/tb_reset_seq_gen.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/reset_seq_gen.sv
// Reset sequence generator: turns async power-on and sync software requests into
// flop-driven preset/clear pulses held HOLD_CYCLES cycles, released synchronously.
module reset_seq_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic preset_n,
  input  logic sw_req,
  input  logic mode,
  output logic rst_clr_n,
  output logic rst_preset_n,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HOLD = 2'd1,
    ST_IDLE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   mode_q, mode_d;
  logic                   clr_n_d, pre_n_d, busy_d, done_d;

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      state_q      <= ST_SYNC;
      sync_q       <= '0;
      cnt_q        <= '0;
      mode_q       <= 1'b1;
      rst_clr_n    <= 1'b1;
      rst_preset_n <= 1'b0;
      busy         <= 1'b1;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      rst_clr_n    <= clr_n_d;
      rst_preset_n <= pre_n_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
    cnt_d   = '0;
    mode_d  = mode_q;
    clr_n_d = rst_clr_n;
    pre_n_d = rst_preset_n;
    done_d  = 1'b0;
    case (state_q)
      ST_SYNC: begin
        clr_n_d = mode_q;
        pre_n_d = !mode_q;
        // Leave SYNC on the edge that loads 1 into the last stage, so the
        // synchronizer depth counts in full toward the release edge.
        if (sync_d[SYNC_STAGES-1]) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          clr_n_d = 1'b1;
          pre_n_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          clr_n_d = mode_q;
          pre_n_d = !mode_q;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (sw_req) begin
          mode_d  = mode;
          clr_n_d = mode;
          pre_n_d = !mode;
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_SYNC;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_reset_seq_gen.sv
// Directed bench for reset_seq_gen with SYNC_STAGES=2, HOLD_CYCLES=4.
module tb_reset_seq_gen;

  logic clk = 1'b0;
  logic preset_n = 1'b1;
  logic sw_req = 1'b0;
  logic mode = 1'b0;
  logic rst_clr_n, rst_preset_n, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    logic  sw;
    logic  md;
    logic  clr_n;
    logic  pre_n;
    logic  bsy;
    logic  dn;
  } vec_t;

  vec_t tbl[$];

  reset_seq_gen #(.SYNC_STAGES(2), .HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk),
    .preset_n(preset_n),
    .sw_req(sw_req),
    .mode(mode),
    .rst_clr_n(rst_clr_n),
    .rst_preset_n(rst_preset_n),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic c, input logic p, input logic b, input logic d);
    chk({name, ".rst_clr_n"}, rst_clr_n, c);
    chk({name, ".rst_preset_n"}, rst_preset_n, p);
    chk({name, ".busy"}, busy, b);
    chk({name, ".done"}, done, d);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string tag, input logic sw, input logic md,
                     input logic c, input logic p, input logic b, input logic d);
    vec_t v;
    v.tag = tag; v.sw = sw; v.md = md;
    v.clr_n = c; v.pre_n = p; v.bsy = b; v.dn = d;
    tbl.push_back(v);
  endtask

  // Release preset_n between edges and verify release at the 6th edge.
  task automatic power_on_release(input string tag);
    @(negedge clk);
    preset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 6)       chk4($sformatf("%s.e%0d", tag, k), 1'b1, 1'b0, 1'b1, 1'b0);
      else if (k == 6) chk4($sformatf("%s.e%0d", tag, k), 1'b1, 1'b1, 1'b0, 1'b1);
      else             chk4($sformatf("%s.e%0d", tag, k), 1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // Software clear
    add("swclr", 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) add("swclr", 0, 0, 0, 1, 1, 0);
    add("swclr", 0, 0, 1, 1, 0, 1);
    add("swclr", 0, 0, 1, 1, 0, 0);
    // Software preset
    add("swpre", 1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) add("swpre", 0, 0, 1, 0, 1, 0);
    add("swpre", 0, 0, 1, 1, 0, 1);
    add("swpre", 0, 0, 1, 1, 0, 0);
    // Requests during HOLD are ignored, mode change included
    add("busyreq", 1, 0, 0, 1, 1, 0);
    add("busyreq", 1, 1, 0, 1, 1, 0);
    add("busyreq", 0, 1, 0, 1, 1, 0);
    add("busyreq", 1, 1, 0, 1, 1, 0);
    add("busyreq", 1, 1, 1, 1, 0, 1);
    add("busyreq", 0, 0, 1, 1, 0, 0);
    add("busyreq", 0, 0, 1, 1, 0, 0);
    // Held request: 4 cycles asserted, 1 cycle released with done
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) add("held", 1, 0, 0, 1, 1, 0);
      add("held", 1, 0, 1, 1, 0, 1);
    end
    add("held", 0, 0, 1, 1, 0, 0);

    // Power-on
    #1 preset_n = 1'b0;
    #1 chk4("reset", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk4($sformatf("reset.c%0d", k), 1'b1, 1'b0, 1'b1, 1'b0);
    end
    power_on_release("poweron");

    foreach (tbl[i]) begin
      sw_req = tbl[i].sw;
      mode   = tbl[i].md;
      tick();
      chk4($sformatf("%s[%0d]", tbl[i].tag, i), tbl[i].clr_n, tbl[i].pre_n, tbl[i].bsy, tbl[i].dn);
    end
    sw_req = 1'b0;

    // Async abort in the 2nd HOLD cycle of a clear sequence
    sw_req = 1'b1; mode = 1'b0;
    tick();
    sw_req = 1'b0;
    tick();
    chk4("abort.pre", 1'b0, 1'b1, 1'b1, 1'b0);
    #2 preset_n = 1'b0;
    #1 chk4("abort.async", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk4("abort.held", 1'b1, 1'b0, 1'b1, 1'b0);
    power_on_release("abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
